// File: rtl/fifo_sb_pkg.sv
// Shared types and helpers for the FIFO scoreboard checker.
// Error vectors are carried as one packed struct so sticky and event logic stay aligned.
package fifo_sb_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic flag;
    logic data;
  } err_vec_t;

  // Occupancy must represent 0..SB_DEPTH inclusive, hence one extra bit.
  function automatic int occ_width(input int sb_depth);
    return $clog2(sb_depth) + 1;
  endfunction

endpackage

// File: rtl/sb_delay_line.sv
// Valid+data shift pipe of LAT registered stages.
// Only the valid bits are reset, so in-flight entries vanish on reset.
module sb_delay_line #(
  parameter int W   = 4,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld_q;
  logic [W-1:0]   data_q [LAT];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value, so the loop shifts instead of collapsing.
      vld_q[0] <= in_vld;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // NOTE: the data stages carry no reset; a stage's content is only looked at while its valid bit is set.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_data = data_q[LAT-1];

endmodule

// File: rtl/fifo_sb_checker.sv
// Scoreboard/checker for a single-clock FIFO: mirrors accepted pushes/pops, predicts read
// data after RD_LAT cycles and reports overflow, underflow, flag and data errors.
module fifo_sb_checker
  import fifo_sb_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 4,
  parameter int SB_DEPTH  = 8,
  parameter int RD_LAT    = 1,
  parameter int ERR_CNT_W = 8,
  // Clear to silence the concurrent assertions when errors are provoked on purpose.
  parameter bit ASSERT_EN = 1'b1,
  localparam int OCC_W    = occ_width(SB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 clr,
  input  logic                 vld_in,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 vld_out,
  input  logic [DATA_W-1:0]    data_out,
  input  logic                 full_dut,
  input  logic                 empty_dut,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 chk_vld,
  output logic [DATA_W-1:0]    exp_data,
  output logic                 err_ovf,
  output logic                 err_udf,
  output logic                 err_flag,
  output logic                 err_data,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);

  logic [DATA_W-1:0]    mem [SB_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 model_full, model_empty;
  logic                 push_ok, pop_ok;
  logic [DATA_W-1:0]    exp_next;
  logic                 dl_vld;
  logic [DATA_W-1:0]    dl_data;
  err_vec_t             ev, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign model_full  = (occ == OCC_W'(DEPTH));
  assign model_empty = (occ == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    exp_next = mem[rd_ptr];
    ev       = '0;

    // A simultaneous pop frees a slot, so a push at full still lands.
    push_ok = vld_in && (!model_full || vld_out);
    // A simultaneous push makes a pop at empty a bypass of the pushed word.
    pop_ok  = vld_out && (!model_empty || vld_in);
    if (model_empty) begin
      exp_next = data_in;
    end

    ev.ovf  = vld_in && !vld_out && model_full;
    ev.udf  = vld_out && !vld_in && model_empty;
    ev.flag = (full_dut != model_full) || (empty_dut != model_empty);
    ev.data = chk_vld && (data_out != exp_data);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  sb_delay_line #(
    .W   (DATA_W),
    .LAT (RD_LAT)
  ) u_exp_dl (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_vld   (pop_ok),
    .in_data  (exp_next),
    .out_vld  (dl_vld),
    .out_data (dl_data)
  );

  assign chk_vld  = dl_vld;
  assign exp_data = dl_vld ? dl_data : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_q     <= '0;
      err_cnt_q <= '0;
    end else if (clr) begin
      err_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q <= err_vec_t'(err_q | ev);
      if ((|ev) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign occupancy = occ;
  assign err_ovf   = err_q.ovf;
  assign err_udf   = err_q.udf;
  assign err_flag  = err_q.flag;
  assign err_data  = err_q.data;
  assign err_count = err_cnt_q;

  lat_range: assert property (@(posedge clk) (RD_LAT >= 1) && (RD_LAT <= RD_LAT_MAX));

  if (ASSERT_EN) begin : g_assert
    no_overflow:    assert property (@(posedge clk) disable iff (!rst_b) !ev.ovf);
    no_underflow:   assert property (@(posedge clk) disable iff (!rst_b) !ev.udf);
    flag_match:     assert property (@(posedge clk) disable iff (!rst_b) !ev.flag);
    data_integrity: assert property (@(posedge clk) disable iff (!rst_b) !ev.data);
  end

endmodule

// File: tb/tb_fifo_sb_checker.sv
// Bench for fifo_sb_checker: emulates a FIFO's accept/flag/read-data behaviour around two
// checker instances (RD_LAT=1 and RD_LAT=3) and scoreboards every predicted compare.
module tb_fifo_sb_checker;

  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic          clr_a, vld_in_a, vld_out_a, full_a, empty_a;
  logic [DW-1:0] din_a, dout_a, exp_a;
  logic [3:0]    occ_a;
  logic          chk_a, ovf_a, udf_a, flag_a, data_a;
  logic [7:0]    cnt_err_a;

  logic          clr_b, vld_in_b, vld_out_b, full_b, empty_b;
  logic [DW-1:0] din_b, dout_b, exp_b;
  logic [3:0]    occ_b;
  logic          chk_b, ovf_b, udf_b, flag_b, data_b;
  logic [7:0]    cnt_err_b;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] q_a [$];
  logic [DW-1:0] q_b [$];
  int n_chk_a = 0, n_chk_b = 0;
  int fill_a = 0, fill_b = 0;
  bit force_full_a = 1'b0;

  fifo_sb_checker #(
    .DATA_W(DW), .DEPTH(DEPTH), .SB_DEPTH(8), .RD_LAT(1), .ERR_CNT_W(8), .ASSERT_EN(1'b0)
  ) u_dut_a (
    .clk(clk), .rst_b(rst_b), .clr(clr_a), .vld_in(vld_in_a), .data_in(din_a),
    .vld_out(vld_out_a), .data_out(dout_a), .full_dut(full_a), .empty_dut(empty_a),
    .occupancy(occ_a), .chk_vld(chk_a), .exp_data(exp_a), .err_ovf(ovf_a),
    .err_udf(udf_a), .err_flag(flag_a), .err_data(data_a), .err_count(cnt_err_a)
  );

  fifo_sb_checker #(
    .DATA_W(DW), .DEPTH(DEPTH), .SB_DEPTH(8), .RD_LAT(3), .ERR_CNT_W(8), .ASSERT_EN(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_b(rst_b), .clr(clr_b), .vld_in(vld_in_b), .data_in(din_b),
    .vld_out(vld_out_b), .data_out(dout_b), .full_dut(full_b), .empty_dut(empty_b),
    .occupancy(occ_b), .chk_vld(chk_b), .exp_data(exp_b), .err_ovf(ovf_b),
    .err_udf(udf_b), .err_flag(flag_b), .err_data(data_b), .err_count(cnt_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Every compare the checker announces must match the oldest pop the bench issued.
  always @(negedge clk) begin
    if (rst_b) begin
      if (chk_a) begin
        n_chk_a++;
        check("cmp_pending_a", 32'(q_a.size() != 0), 1);
        if (q_a.size() != 0) check("exp_data_a", 32'(exp_a), 32'(q_a.pop_front()));
      end
      if (chk_b) begin
        n_chk_b++;
        check("cmp_pending_b", 32'(q_b.size() != 0), 1);
        if (q_b.size() != 0) check("exp_data_b", 32'(exp_b), 32'(q_b.pop_front()));
      end
    end
  end

  task automatic flags_a();
    full_a  = (fill_a == DEPTH) || force_full_a;
    empty_a = (fill_a == 0);
  endtask

  task automatic flags_b();
    full_b  = (fill_b == DEPTH);
    empty_b = (fill_b == 0);
  endtask

  task automatic cyc_a(input bit push, input logic [DW-1:0] d, input bit pop,
                       input logic [DW-1:0] rd, input bit do_clr = 1'b0);
    vld_in_a = push; din_a = d; vld_out_a = pop; dout_a = rd; clr_a = do_clr;
    flags_a();
    @(posedge clk); #1;
    if (push && !pop && fill_a < DEPTH) fill_a++;
    else if (pop && !push && fill_a > 0) fill_a--;
    vld_in_a = 1'b0; vld_out_a = 1'b0; clr_a = 1'b0;
    flags_a();
  endtask

  task automatic cyc_b(input bit push, input logic [DW-1:0] d, input bit pop,
                       input logic [DW-1:0] rd, input bit do_clr = 1'b0);
    vld_in_b = push; din_b = d; vld_out_b = pop; dout_b = rd; clr_b = do_clr;
    flags_b();
    @(posedge clk); #1;
    if (push && !pop && fill_b < DEPTH) fill_b++;
    else if (pop && !push && fill_b > 0) fill_b--;
    vld_in_b = 1'b0; vld_out_b = 1'b0; clr_b = 1'b0;
    flags_b();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    vld_in_a = 1'b0; vld_out_a = 1'b0; clr_a = 1'b0; din_a = '0; dout_a = '0;
    vld_in_b = 1'b0; vld_out_b = 1'b0; clr_b = 1'b0; din_b = '0; dout_b = '0;
    fill_a = 0; fill_b = 0; force_full_a = 1'b0;
    q_a.delete(); q_b.delete();
    flags_a(); flags_b();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d [21];
    int base;

    do_reset();
    check("rst_occ_a", 32'(occ_a), 0);
    check("rst_chk_a", 32'(chk_a), 0);
    check("rst_exp_a", 32'(exp_a), 0);
    check("rst_err_a", 32'({ovf_a, udf_a, flag_a, data_a}), 0);
    check("rst_cnt_a", 32'(cnt_err_a), 0);
    check("rst_occ_b", 32'(occ_b), 0);
    check("rst_err_b", 32'({chk_b, ovf_b, udf_b, flag_b, data_b}), 0);

    // 1: three pushes then three pops with matching read data
    cyc_a(1'b1, 4'h3, 1'b0, 4'h0);
    cyc_a(1'b1, 4'h5, 1'b0, 4'h0);
    cyc_a(1'b1, 4'h9, 1'b0, 4'h0);
    check("t1_occ3", 32'(occ_a), 3);
    base = n_chk_a;
    q_a.push_back(4'h3); cyc_a(1'b0, 4'h0, 1'b1, 4'h0);
    q_a.push_back(4'h5); cyc_a(1'b0, 4'h0, 1'b1, 4'h3);
    q_a.push_back(4'h9); cyc_a(1'b0, 4'h0, 1'b1, 4'h5);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h9);
    check("t1_ncmp", n_chk_a - base, 3);
    check("t1_err", 32'({ovf_a, udf_a, flag_a, data_a}), 0);
    check("t1_occ0", 32'(occ_a), 0);

    // 2: overflow push is dropped and never predicted
    for (int i = 1; i <= 4; i++) cyc_a(1'b1, 4'(i), 1'b0, 4'h0);
    check("t2_occ_full", 32'(occ_a), 4);
    cyc_a(1'b1, 4'hA, 1'b0, 4'h0);
    check("t2_ovf", 32'(ovf_a), 1);
    check("t2_cnt", 32'(cnt_err_a), 1);
    check("t2_occ_hold", 32'(occ_a), 4);
    check("t2_other_err", 32'({udf_a, flag_a, data_a}), 0);
    q_a.push_back(4'h1); cyc_a(1'b0, 4'h0, 1'b1, 4'h0);
    q_a.push_back(4'h2); cyc_a(1'b0, 4'h0, 1'b1, 4'h1);
    q_a.push_back(4'h3); cyc_a(1'b0, 4'h0, 1'b1, 4'h2);
    q_a.push_back(4'h4); cyc_a(1'b0, 4'h0, 1'b1, 4'h3);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h4);
    check("t2_drain_data", 32'(data_a), 0);
    check("t2_drain_occ", 32'(occ_a), 0);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check("t2_clr", 32'({ovf_a, cnt_err_a}), 0);

    // 3: bypass at empty, then a lone pop at empty
    q_a.push_back(4'h7); cyc_a(1'b1, 4'h7, 1'b1, 4'h0);
    check("t3_byp_occ", 32'(occ_a), 0);
    check("t3_byp_udf", 32'(udf_a), 0);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h7);
    check("t3_byp_err", 32'({data_a, cnt_err_a}), 0);
    base = n_chk_a;
    cyc_a(1'b0, 4'h0, 1'b1, 4'h0);
    check("t3_udf", 32'(udf_a), 1);
    check("t3_udf_cnt", 32'(cnt_err_a), 1);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h0);
    check("t3_udf_nocmp", n_chk_a - base, 0);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // 4: RD_LAT=3, back-to-back pops, second read word corrupted
    cyc_b(1'b1, 4'h1, 1'b0, 4'h0);
    cyc_b(1'b1, 4'h2, 1'b0, 4'h0);
    base = n_chk_b;
    q_b.push_back(4'h1); cyc_b(1'b0, 4'h0, 1'b1, 4'h0);
    q_b.push_back(4'h2); cyc_b(1'b0, 4'h0, 1'b1, 4'h0);
    check("t4_chk_c2", 32'(chk_b), 0);
    cyc_b(1'b0, 4'h0, 1'b0, 4'h0);
    check("t4_chk_c3", 32'(chk_b), 1);
    cyc_b(1'b0, 4'h0, 1'b0, 4'h1);
    check("t4_chk_c4", 32'(chk_b), 1);
    check("t4_data_c4", 32'(data_b), 0);
    cyc_b(1'b0, 4'h0, 1'b0, 4'h6);
    check("t4_data_set", 32'(data_b), 1);
    check("t4_cnt", 32'(cnt_err_b), 1);
    check("t4_chk_c5", 32'(chk_b), 0);
    check("t4_ncmp", n_chk_b - base, 2);
    cyc_b(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check("t4_clr", 32'({data_b, cnt_err_b}), 0);

    // 5: DUT full flag wrong at occ=2, then clr
    cyc_a(1'b1, 4'h1, 1'b0, 4'h0);
    cyc_a(1'b1, 4'h2, 1'b0, 4'h0);
    force_full_a = 1'b1;
    cyc_a(1'b0, 4'h0, 1'b0, 4'h0);
    force_full_a = 1'b0;
    check("t5_flag", 32'(flag_a), 1);
    check("t5_cnt", 32'(cnt_err_a), 1);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check("t5_clr", 32'({flag_a, cnt_err_a}), 0);
    check("t5_occ", 32'(occ_a), 2);
    q_a.push_back(4'h1); cyc_a(1'b0, 4'h0, 1'b1, 4'h0);
    q_a.push_back(4'h2); cyc_a(1'b0, 4'h0, 1'b1, 4'h1);
    cyc_a(1'b0, 4'h0, 1'b0, 4'h2);

    // 6: 20 push/pop pairs across pointer wrap
    for (int i = 0; i < 21; i++) d[i] = 4'($urandom_range(0, 15));
    base = n_chk_a;
    cyc_a(1'b1, d[0], 1'b0, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      q_a.push_back(d[k-1]);
      cyc_a(1'b1, d[k], 1'b1, (k >= 2) ? d[k-2] : 4'h0);
    end
    q_a.push_back(d[20]); cyc_a(1'b0, 4'h0, 1'b1, d[19]);
    cyc_a(1'b0, 4'h0, 1'b0, d[20]);
    check("t6_ncmp", n_chk_a - base, 21);
    check("t6_err", 32'({ovf_a, udf_a, flag_a, data_a, cnt_err_a}), 0);
    check("t6_occ", 32'(occ_a), 0);

    // 6b: reset with compares in flight
    cyc_b(1'b1, 4'h4, 1'b0, 4'h0);
    cyc_b(1'b1, 4'h5, 1'b0, 4'h0);
    cyc_b(1'b1, 4'h6, 1'b0, 4'h0);
    q_b.push_back(4'h4); cyc_b(1'b0, 4'h0, 1'b1, 4'h0);
    q_b.push_back(4'h5); cyc_b(1'b0, 4'h0, 1'b1, 4'h0);
    do_reset();
    check("t6_rst_occ", 32'(occ_b), 0);
    check("t6_rst_chk", 32'(chk_b), 0);
    base = n_chk_b;
    repeat (6) cyc_b(1'b0, 4'h0, 1'b0, 4'h0);
    check("t6_no_stray", n_chk_b - base, 0);
    check("t6_rst_err", 32'({ovf_b, udf_b, flag_b, data_b, cnt_err_b}), 0);

    check("left_a", q_a.size(), 0);
    check("left_b", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
